// File: rtl/vobstacle_pkg.sv
// Shared types and lane helpers for the vertical obstacle sequencer.
// Lane speeds, directions and reset positions are derived from the lane index.
package vobstacle_pkg;

    localparam int unsigned N_LANES = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_UPD,
        S_PAUSE,
        S_HIT
    } state_t;

    function automatic logic [2:0] lane_speed(input logic [1:0] idx);
        return {1'b0, idx} + 3'd1;
    endfunction

    // Even lanes fall, odd lanes rise.
    function automatic logic lane_down(input logic [1:0] idx);
        return ~idx[0];
    endfunction

    function automatic logic [9:0] lane_reset_y(input int unsigned idx,
                                                input int unsigned y_min,
                                                input int unsigned spacing);
        return 10'(y_min + idx * spacing);
    endfunction

    // One frame of motion for one lane, at 11 bits so y+spd cannot overflow.
    function automatic logic [9:0] lane_step(input logic [9:0]  y,
                                             input logic [1:0]  idx,
                                             input logic [10:0] y_min,
                                             input logic [10:0] y_max);
        logic [10:0] spd;
        logic [10:0] y11;
        logic [10:0] n;
        logic [9:0]  res;
        spd = {8'd0, lane_speed(idx)};
        y11 = {1'b0, y};
        if (lane_down(idx)) begin
            n   = y11 + spd;
            res = (n > y_max) ? y_min[9:0] : n[9:0];
        end else begin
            n   = y11 - spd;
            res = (y11 < (y_min + spd)) ? y_max[9:0] : n[9:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/vobstacle_sched_render.sv
// Pixel window compare for one obstacle lane: column span, bar height, bottom clip.
module vobs_lane_render #(
    parameter int unsigned LANE_X = 308,
    parameter int unsigned OBS_W  = 8,
    parameter int unsigned OBS_H  = 32,
    parameter int unsigned Y_MAX  = 471
) (
    input  logic [9:0] hcount_i,
    input  logic [9:0] vcount_i,
    input  logic [9:0] y_top_i,
    output logic       on_o
);

    logic [10:0] h;
    logic [10:0] v;
    logic [10:0] y_lo;
    logic [10:0] y_hi;

    always_comb begin
        h    = {1'b0, hcount_i};
        v    = {1'b0, vcount_i};
        y_lo = {1'b0, y_top_i};
        y_hi = y_lo + 11'(OBS_H - 1);
        on_o = (h >= 11'(LANE_X)) && (h <= 11'(LANE_X + OBS_W - 1)) &&
               (v >= y_lo) && (v <= y_hi) && (v <= 11'(Y_MAX));
    end

endmodule

// File: rtl/vobstacle_sched.sv
// Four-lane vertical obstacle sequencer: per-frame lane motion, red bar render,
// sticky player collision, and the run/update/pause/hit control FSM.
module vobstacle_sched
    import vobstacle_pkg::*;
#(
    parameter int unsigned LANE_X0      = 308,
    parameter int unsigned LANE_PITCH   = 40,
    parameter int unsigned OBS_W        = 8,
    parameter int unsigned OBS_H        = 32,
    parameter int unsigned Y_MIN        = 8,
    parameter int unsigned Y_MAX        = 471,
    parameter int unsigned LANE_SPACING = 96
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       pause,
    input  logic [9:0] Hcount,
    input  logic [9:0] Vcount,
    input  logic       player_px,
    output logic [3:0] Red,
    output logic       hit,
    output logic       running
);

    state_t                   state_q, state_d;
    logic [1:0]               idx_q, idx_d;
    logic                     pause_lat_q, pause_lat_d;
    logic                     hit_q, hit_d;
    logic [3:0]               red_q;
    logic                     pp_q;
    logic [N_LANES-1:0][9:0]  y_q, y_d, y_rst;
    logic [N_LANES-1:0]       lane_on;
    logic                     coin;

    always_comb begin
        for (int unsigned i = 0; i < N_LANES; i++) begin
            y_rst[i] = lane_reset_y(i, Y_MIN, LANE_SPACING);
        end
    end

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        vobs_lane_render #(
            .LANE_X(LANE_X0 + g * LANE_PITCH),
            .OBS_W (OBS_W),
            .OBS_H (OBS_H),
            .Y_MAX (Y_MAX)
        ) u_render (
            .hcount_i(Hcount),
            .vcount_i(Vcount),
            .y_top_i (y_q[g]),
            .on_o    (lane_on[g])
        );
    end

    assign coin = (red_q != 4'h0) && pp_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pause_lat_d = pause_lat_q;
        y_d         = y_q;
        hit_d       = hit_q | (coin && ((state_q == S_RUN) || (state_q == S_UPD)));
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                if (hit_q) begin
                    state_d = S_HIT;
                end else if (pause) begin
                    state_d = S_PAUSE;
                end else if (frame_tick) begin
                    state_d     = S_UPD;
                    idx_d       = '0;
                    pause_lat_d = 1'b0;
                end
            end
            S_UPD: begin
                // A pause arriving mid-update is remembered; the sweep always finishes.
                y_d[idx_q]  = lane_step(y_q[idx_q], idx_q, 11'(Y_MIN), 11'(Y_MAX));
                pause_lat_d = pause_lat_q | pause;
                idx_d       = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    if (pause_lat_q | pause) begin
                        state_d = S_PAUSE;
                    end else if (hit_q) begin
                        state_d = S_HIT;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_PAUSE: begin
                if (start) state_d = S_RUN;
            end
            S_HIT: begin
                if (start) begin
                    state_d = S_RUN;
                    hit_d   = 1'b0;
                    y_d     = y_rst;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            pause_lat_q <= 1'b0;
            hit_q       <= 1'b0;
            red_q       <= '0;
            pp_q        <= 1'b0;
            y_q         <= y_rst;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pause_lat_q <= pause_lat_d;
            hit_q       <= hit_d;
            red_q       <= (|lane_on) ? 4'hF : 4'h0;
            pp_q        <= player_px;
            y_q         <= y_d;
        end
    end

    assign Red     = red_q;
    assign hit     = hit_q;
    assign running = (state_q == S_RUN) || (state_q == S_UPD);

endmodule

// File: tb/tb_vobstacle_sched.sv
// Directed bench for vobstacle_sched with an independent lane-position model
// and a scoreboard queue of expected Red values.
module tb_vobstacle_sched;
    import vobstacle_pkg::*;

    logic       clk = 1'b0;
    logic       reset, frame_tick, start, pause, player_px;
    logic [9:0] Hcount, Vcount;
    logic [3:0] Red;
    logic       hit, running;

    vobstacle_sched dut (
        .clk       (clk),
        .reset     (reset),
        .frame_tick(frame_tick),
        .start     (start),
        .pause     (pause),
        .Hcount    (Hcount),
        .Vcount    (Vcount),
        .player_px (player_px),
        .Red       (Red),
        .hit       (hit),
        .running   (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] red;
    } exp_t;

    exp_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   my[4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) my[i] = 8 + 96 * i;
    endfunction

    function automatic void model_frame();
        for (int i = 0; i < 4; i++) begin
            int spd;
            spd = i + 1;
            if (i % 2 == 0) begin
                if (my[i] + spd > 471) my[i] = 8;
                else my[i] = my[i] + spd;
            end else begin
                if (my[i] - spd < 8) my[i] = 471;
                else my[i] = my[i] - spd;
            end
        end
    endfunction

    function automatic logic [3:0] model_red(input int h, input int v);
        for (int i = 0; i < 4; i++) begin
            int x;
            x = 308 + 40 * i;
            if (h >= x && h < x + 8 && v >= my[i] && v < my[i] + 32 && v <= 471) return 4'hF;
        end
        return 4'h0;
    endfunction

    task automatic probe(input int h, input int v);
        exp_t e;
        Hcount = 10'(h);
        Vcount = 10'(v);
        sbq.push_back('{$sformatf("red@%0d,%0d", h, v), model_red(h, v)});
        tick();
        e = sbq.pop_front();
        check(e.tag, 32'(Red), 32'(e.red));
    endtask

    task automatic check_pos();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("y_top%0d", i), 32'(dut.y_q[i]), 32'(my[i]));
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Stray frame_tick at c==3 exercises the ignore-during-update rule.
    task automatic run_frame(input int pause_at, input bit chk);
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (chk) begin
                check($sformatf("upd_state_c%0d", c), 32'(dut.state_q), 32'(S_UPD));
                check($sformatf("upd_running_c%0d", c), 32'(running), 32'd1);
                if (c == 3) frame_tick = 1'b1;
            end
            if (c == pause_at) pause = 1'b1;
            tick();
            pause      = 1'b0;
            frame_tick = 1'b0;
        end
        model_frame();
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; start = 1'b0; pause = 1'b0; player_px = 1'b0;
        Hcount = '0; Vcount = '0;
        model_reset();
        repeat (3) tick();
        check("rst_red", 32'(Red), 32'h0);
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(S_IDLE));
        reset = 1'b0;
        tick();
        check_pos();

        probe(308, 8);
        probe(308, 7);
        probe(316, 8);
        probe(348, 104);

        pulse_start();
        check("start_state", 32'(dut.state_q), 32'(S_RUN));
        check("start_running", 32'(running), 32'd1);
        run_frame(0, 1'b1);
        check("frame1_state", 32'(dut.state_q), 32'(S_RUN));
        check_pos();
        probe(348, 102);
        probe(348, 101);

        for (int f = 1; f < 48; f++) run_frame(0, 1'b0);
        check_pos();
        probe(348, 8);
        probe(348, 7);
        run_frame(0, 1'b0);
        check_pos();
        probe(348, 471);
        probe(348, 470);
        for (int f = 49; f < 463; f++) run_frame(0, 1'b0);
        check_pos();
        probe(308, 471);
        probe(308, 470);
        run_frame(0, 1'b0);
        check_pos();
        probe(308, 8);
        for (int f = 464; f < 916; f++) run_frame(0, 1'b0);
        check_pos();
        probe(308, 459);
        probe(308, 460);
        probe(308, 471);
        probe(308, 472);

        run_frame(2, 1'b1);
        check("pause_state", 32'(dut.state_q), 32'(S_PAUSE));
        check("pause_running", 32'(running), 32'd0);
        check_pos();
        repeat (2) begin
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
            repeat (5) tick();
        end
        check("paused_state", 32'(dut.state_q), 32'(S_PAUSE));
        check_pos();
        pulse_start();
        check("resume_state", 32'(dut.state_q), 32'(S_RUN));
        run_frame(0, 1'b1);
        check("resume_frame_state", 32'(dut.state_q), 32'(S_RUN));
        check_pos();

        Hcount = 10'd308;
        Vcount = 10'(my[0]);
        player_px = 1'b1;
        tick();
        check("hit_after1", 32'(hit), 32'd0);
        player_px = 1'b0;
        Hcount = '0;
        Vcount = '0;
        tick();
        check("hit_after2", 32'(hit), 32'd1);
        tick();
        check("hit_state", 32'(dut.state_q), 32'(S_HIT));
        check("hit_running", 32'(running), 32'd0);
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        repeat (5) tick();
        check("hit_sticky", 32'(hit), 32'd1);
        check_pos();
        pulse_start();
        model_reset();
        check("restart_hit", 32'(hit), 32'd0);
        check("restart_state", 32'(dut.state_q), 32'(S_RUN));
        check_pos();
        probe(308, 8);

        Hcount = 10'd308;
        Vcount = 10'd13;
        tick();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        player_px = 1'b1;
        tick();
        player_px = 1'b0;
        tick();
        check("upd_hit", 32'(hit), 32'd1);
        check("upd_red", 32'(Red), 32'hF);
        check("upd_run", 32'(running), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_red", 32'(Red), 32'h0);
        check("async_hit", 32'(hit), 32'd0);
        check("async_running", 32'(running), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        model_reset();
        tick();
        check("post_rst_state", 32'(dut.state_q), 32'(S_IDLE));
        check_pos();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
